// File: rtl/seg7_scan_ctrl_if.sv
// Load channel for the 7-segment scan controller: packed BCD value with valid/ready.
interface seg7_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    load_valid;
   logic                    load_ready;
   logic [4*NUM_DIGITS-1:0] load_data;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a one-deep pending buffer
// that is committed to the display only on frame boundaries.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  clk,
   input  logic                  reset,
   seg7_scan_ctrl_if.slave       load,
   input  logic                  blank_lz,
   output logic [6:0]            seg,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  frame_done
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t                  state, state_next;
   logic [CNT_W-1:0]        cnt, cnt_next;
   logic [IDX_W-1:0]        idx, idx_next;
   logic [4*NUM_DIGITS-1:0] display, display_next, pending;
   logic                    pending_full;
   logic                    boundary, transfer;
   logic [6:0]              seg_next;
   logic [NUM_DIGITS-1:0]   digit_en_next;
   logic                    frame_done_next;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'h0:    return 7'h3F;
         4'h1:    return 7'h06;
         4'h2:    return 7'h5B;
         4'h3:    return 7'h4F;
         4'h4:    return 7'h66;
         4'h5:    return 7'h6D;
         4'h6:    return 7'h7D;
         4'h7:    return 7'h07;
         4'h8:    return 7'h7F;
         4'h9:    return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   assign boundary       = (idx == IDX_LAST) && (cnt == CNT_LAST);
   assign transfer       = load.load_valid && !pending_full;
   assign load.load_ready = ~pending_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= BLANK;
         cnt          <= '0;
         idx          <= '0;
         display      <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         seg          <= '0;
         digit_en     <= '0;
         frame_done   <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         idx        <= idx_next;
         display    <= display_next;
         seg        <= seg_next;
         digit_en   <= digit_en_next;
         frame_done <= frame_done_next;
         // Commit and accept are exclusive: a transfer needs pending empty.
         if (boundary && pending_full) begin
            pending_full <= 1'b0;
         end else if (transfer) begin
            pending      <= load.load_data;
            pending_full <= 1'b1;
         end
      end
   end

   always_comb begin
      cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      idx_next = idx;
      if (cnt == CNT_LAST) begin
         idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      state_next = state;
      case (state)
         BLANK:   if (int'(cnt_next) >= BLANK_CYCLES) state_next = DRIVE;
         DRIVE:   if (cnt == CNT_LAST && BLANK_CYCLES > 0) state_next = BLANK;
         default: state_next = BLANK;
      endcase
      display_next = (boundary && pending_full) ? pending : display;
   end

   // Output registers are loaded from next-state values so they line up
   // with the state/idx of the cycle in which they are visible.
   always_comb begin
      logic [NUM_DIGITS-1:0] zero_from;
      logic                  run_zero;
      logic [3:0]            nib;
      logic                  lz_hit;
      run_zero = 1'b1;
      zero_from = '0;
      nib = '0;
      lz_hit = 1'b0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         run_zero = run_zero && (display_next[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
         zero_from[NUM_DIGITS-1-j] = run_zero;
      end
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (idx_next == IDX_W'(k)) begin
            nib    = display_next[4*k +: 4];
            lz_hit = (k != 0) && zero_from[k];
         end
      end
      seg_next      = '0;
      digit_en_next = '0;
      if (state_next == DRIVE) begin
         digit_en_next = NUM_DIGITS'(1) << idx_next;
         seg_next      = (blank_lz && lz_hit) ? '0 : decode(nib);
      end
      frame_done_next = (idx_next == IDX_LAST) && (cnt_next == CNT_LAST);
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: per-cycle reference model, decode/blanking vector
// table, and hand sequences for back-to-back loads, boundary transfer and reset.
module tb_seg7_scan_ctrl;
   localparam int ND = 4;
   localparam int SD = 8;
   localparam int BC = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       blank_lz = 1'b0;
   logic [6:0] seg;
   logic [3:0] digit_en;
   logic       frame_done;

   seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();

   seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (bus),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // reference model: position derived from cycles since reset release
   int unsigned m_t;
   logic [15:0] m_disp, m_pend;
   logic        m_full, m_lz;
   logic [6:0]  seg_tab [16];

   logic [6:0]  cap [4];
   int          en_cnt [4];
   int          fd_cnt, lit_cnt;

   typedef struct {
      logic [15:0] data;
      logic        lz;
      logic [27:0] exp;   // {d3,d2,d1,d0}
   } vec_t;
   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [6:0] ref_seg(input int unsigned k);
      logic [15:0] above;
      above = m_disp >> (4*k);
      if (m_lz && k != 0 && above == 16'h0) return 7'h00;
      return seg_tab[above[3:0]];
   endfunction

   task automatic model_reset();
      m_t = 0; m_disp = '0; m_pend = '0; m_full = 1'b0; m_lz = 1'b0;
   endtask

   task automatic clear_stats();
      for (int i = 0; i < 4; i++) begin cap[i] = 7'h7F; en_cnt[i] = 0; end
      fd_cnt = 0; lit_cnt = 0;
   endtask

   // Check current cycle against the model, advance the model across the edge.
   task automatic cycle();
      int unsigned cnt, idx;
      logic        drive, e_fd, xfer;
      logic [3:0]  e_en;
      logic [6:0]  e_seg;
      cnt   = m_t % SD;
      idx   = (m_t / SD) % ND;
      drive = (cnt >= BC);
      e_en  = drive ? 4'(1 << idx) : 4'h0;
      e_seg = drive ? ref_seg(idx) : 7'h00;
      e_fd  = (idx == ND-1) && (cnt == SD-1);
      check($sformatf("cycle%0d", m_t), {19'h0, bus.load_ready, frame_done, digit_en, seg},
            {19'h0, ~m_full, e_fd, e_en, e_seg});
      if (digit_en != 4'h0) begin
         cap[idx] = seg;
         en_cnt[idx]++;
         if (seg == 7'h3F) lit_cnt++;
      end
      if (frame_done) fd_cnt++;
      xfer = bus.load_valid && !m_full;
      if (e_fd && m_full) begin m_disp = m_pend; m_full = 1'b0; end
      if (xfer) begin m_pend = bus.load_data; m_full = 1'b1; end
      m_lz = blank_lz;
      m_t++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [15:0] data);
      int n;
      n = 0;
      while (bus.load_ready !== 1'b1 && n < 100) begin cycle(); n++; end
      if (n >= 100) check("send_timeout", 32'd0, 32'd1);
      bus.load_valid = 1'b1;
      bus.load_data  = data;
      cycle();
      bus.load_valid = 1'b0;
   endtask

   // Run until the boundary that commits a full pending buffer has passed.
   task automatic run_to_commit();
      logic hit;
      for (int n = 0; n < 100; n++) begin
         hit = (frame_done === 1'b1) && (bus.load_ready === 1'b0);
         cycle();
         if (hit) return;
      end
      check("commit_timeout", 32'd0, 32'd1);
   endtask

   task automatic capture_frame();
      clear_stats();
      repeat (ND*SD) cycle();
   endtask

   initial begin
      logic prev_fd, r, f;
      int   n;
      seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      vecs[0] = '{16'h1234, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
      vecs[1] = '{16'h0042, 1'b1, {7'h00, 7'h00, 7'h66, 7'h5B}};
      vecs[2] = '{16'h0042, 1'b0, {7'h3F, 7'h3F, 7'h66, 7'h5B}};
      vecs[3] = '{16'h00A0, 1'b0, {7'h3F, 7'h3F, 7'h40, 7'h3F}};
      vecs[4] = '{16'h5678, 1'b1, {7'h6D, 7'h7D, 7'h07, 7'h7F}};
      vecs[5] = '{16'h9000, 1'b1, {7'h6F, 7'h3F, 7'h3F, 7'h3F}};
      vecs[6] = '{16'h0B00, 1'b1, {7'h00, 7'h40, 7'h3F, 7'h3F}};
      vecs[7] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
      vecs[8] = '{16'hCDEF, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      model_reset();
      clear_stats();

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_outputs", {28'h0, bus.load_ready, frame_done, seg == 7'h0, digit_en == 4'h0},
            {28'h0, 1'b1, 1'b0, 1'b1, 1'b1});

      // idle frame: each digit driven 6 of 8 cycles showing 0
      capture_frame();
      for (int k = 0; k < 4; k++) check($sformatf("idle_en_cnt%0d", k), en_cnt[k], 6);
      check("idle_fd_cnt", fd_cnt, 1);
      check("idle_lit_cnt", lit_cnt, 24);

      foreach (vecs[i]) begin
         blank_lz = vecs[i].lz;
         send(vecs[i].data);
         run_to_commit();
         capture_frame();
         for (int k = 0; k < 4; k++)
            check($sformatf("vec%0d_d%0d", i, k), cap[k], vecs[i].exp[7*k +: 7]);
      end

      // back-to-back loads with valid held
      blank_lz = 1'b0;
      send(16'h1111);
      bus.load_valid = 1'b1;
      bus.load_data  = 16'h00A0;
      prev_fd = 1'b0;
      n = 0;
      while (n < 100) begin
         r = bus.load_ready;
         f = frame_done;
         cycle();
         if (r) break;
         prev_fd = f;
         n++;
      end
      check("b2b_accept_after_boundary", {31'h0, prev_fd && (n < 100)}, 32'd1);
      bus.load_valid = 1'b0;
      run_to_commit();
      capture_frame();
      check("b2b_d1", cap[1], 7'h40);
      check("b2b_d0", cap[0], 7'h3F);

      // transfer exactly on the boundary cycle
      n = 0;
      while (frame_done !== 1'b1 && n < 100) begin cycle(); n++; end
      check("bnd_found", {31'h0, n < 100}, 32'd1);
      bus.load_valid = 1'b1;
      bus.load_data  = 16'h0007;
      cycle();
      bus.load_valid = 1'b0;
      check("bnd_ready_low", {31'h0, bus.load_ready}, 32'd0);
      capture_frame();
      check("bnd_frame1_d0", cap[0], 7'h3F);
      capture_frame();
      check("bnd_frame2_d0", cap[0], 7'h07);

      // reset during digit 2 drive with pending full
      n = 0;
      while (digit_en !== 4'b0001 && n < 100) begin cycle(); n++; end
      send(16'h5555);
      n = 0;
      while (digit_en !== 4'b0100 && n < 100) begin cycle(); n++; end
      check("rst_pending_full", {31'h0, bus.load_ready}, 32'd0);
      #2 reset = 1'b1;
      #1;
      check("rst_async_outputs", {20'h0, bus.load_ready, frame_done, digit_en, seg},
            {20'h0, 1'b1, 1'b0, 4'h0, 7'h00});
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      capture_frame();
      for (int k = 0; k < 4; k++) check($sformatf("rst_disp_d%0d", k), cap[k], 7'h3F);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bus.load_valid = ($urandom % 4) == 0;
         bus.load_data  = 16'($urandom);
         if (($urandom % 40) == 0) blank_lz = ~blank_lz;
         cycle();
      end
      bus.load_valid = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
